// File: rtl/cache_line_arbiter.sv
// cache_line_arbiter: round-robin I/D line arbiter onto one L2 port.
// Latches each granted request until L2 completes, then pulses the owner.
module cache_line_arbiter #(
  parameter  int LINE_WIDTH  = 256,
  localparam int OFFSET_BITS = $clog2(LINE_WIDTH/8)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  imem_read,
  input  logic [31:0]           imem_address,
  output logic [LINE_WIDTH-1:0] imem_rdata,
  output logic                  imem_resp,
  input  logic                  dmem_read,
  input  logic                  dmem_write,
  input  logic [31:0]           dmem_address,
  input  logic [LINE_WIDTH-1:0] dmem_wdata,
  output logic [LINE_WIDTH-1:0] dmem_rdata,
  output logic                  dmem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [31:0]           pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [1:0] {
    IDLE, I_BUSY, D_BUSY, RESP
  } state_t;

  localparam logic [31:0] OFF_MASK =
    (32'h1 << OFFSET_BITS) - 32'h1;

  state_t                  state_q, state_d;
  logic                    last_d_q, last_d_d;
  logic                    pread_q, pread_d;
  logic                    pwrite_q, pwrite_d;
  logic [31:0]             addr_q, addr_d;
  logic [LINE_WIDTH-1:0]   wdata_q, wdata_d;
  logic [LINE_WIDTH-1:0]   irdata_q, irdata_d;
  logic [LINE_WIDTH-1:0]   drdata_q, drdata_d;

  logic req_i, req_d, gnt_i, gnt_d;

  // Arbitration: a tie goes to the side that did not win last.
  always_comb begin
    req_i = imem_read;
    req_d = dmem_read | dmem_write;
    gnt_d = req_d & (~req_i | ~last_d_q);
    gnt_i = req_i & ~gnt_d;
  end

  // Next-state and latched-request logic.
  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    pread_d  = pread_q;
    pwrite_d = pwrite_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    irdata_d = irdata_q;
    drdata_d = drdata_q;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          gnt_d: begin
            state_d  = D_BUSY;
            last_d_d = 1'b1;
            pread_d  = dmem_read;
            pwrite_d = dmem_write;
            addr_d   = dmem_address & ~OFF_MASK;
            if (dmem_write) wdata_d = dmem_wdata;
          end
          gnt_i: begin
            state_d  = I_BUSY;
            last_d_d = 1'b0;
            pread_d  = 1'b1;
            pwrite_d = 1'b0;
            addr_d   = imem_address & ~OFF_MASK;
          end
          default: state_d = IDLE;
        endcase
      end
      I_BUSY, D_BUSY: begin
        if (pmem_resp) begin
          state_d  = RESP;
          pread_d  = 1'b0;
          pwrite_d = 1'b0;
          if (pread_q) begin
            if (state_q == D_BUSY) drdata_d = pmem_rdata;
            else                   irdata_d = pmem_rdata;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any L2 transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      pread_q  <= 1'b0;
      pwrite_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      irdata_q <= '0;
      drdata_q <= '0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      pread_q  <= pread_d;
      pwrite_q <= pwrite_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
    end
  end

  // The owner during RESP is always the last grantee.
  always_comb begin
    imem_resp    = (state_q == RESP) & ~last_d_q;
    dmem_resp    = (state_q == RESP) &  last_d_q;
    imem_rdata   = irdata_q;
    dmem_rdata   = drdata_q;
    pmem_read    = pread_q;
    pmem_write   = pwrite_q;
    pmem_address = addr_q;
    pmem_wdata   = wdata_q;
  end

endmodule

// File: tb/tb_cache_line_arbiter.sv
// tb_cache_line_arbiter: directed vectors, transaction model
// compared every negedge, plus hand-computed literal checks.
module tb_cache_line_arbiter;

  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          imem_read = 1'b0;
  logic [31:0]   imem_address = '0;
  logic [LW-1:0] imem_rdata;
  logic          imem_resp;
  logic          dmem_read = 1'b0;
  logic          dmem_write = 1'b0;
  logic [31:0]   dmem_address = '0;
  logic [LW-1:0] dmem_wdata = '0;
  logic [LW-1:0] dmem_rdata;
  logic          dmem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [31:0]   pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata = '0;
  logic          pmem_resp = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  cache_line_arbiter #(.LINE_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .imem_read(imem_read), .imem_address(imem_address),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [LW-1:0] act,
                     input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Transaction-level model: who owns the L2, and whether the
  // transaction is complete and being reported.
  int            m_owner = 0;
  bit            m_done = 1'b0;
  bit            m_last_d = 1'b0;
  logic          e_pread = 1'b0, e_pwrite = 1'b0;
  logic          e_iresp = 1'b0, e_dresp = 1'b0;
  logic [31:0]   e_addr = '0;
  logic [LW-1:0] e_wdata = '0, e_irdata = '0, e_drdata = '0;

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return a - (a % (LW/8));
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_owner = 0; m_done = 0; m_last_d = 0;
      e_pread = 0; e_pwrite = 0; e_iresp = 0; e_dresp = 0;
      e_addr = '0; e_wdata = '0; e_irdata = '0; e_drdata = '0;
    end else if (m_owner != 0 && m_done) begin
      m_owner = 0; m_done = 0;
      e_iresp = 0; e_dresp = 0;
    end else if (m_owner != 0) begin
      if (pmem_resp) begin
        if (e_pread) begin
          if (m_owner == 2) e_drdata = pmem_rdata;
          else              e_irdata = pmem_rdata;
        end
        e_pread = 0; e_pwrite = 0; m_done = 1;
        e_iresp = (m_owner == 1);
        e_dresp = (m_owner == 2);
      end
    end else begin
      bit wi, wd;
      wi = imem_read;
      wd = dmem_read | dmem_write;
      if (wi && wd) m_owner = m_last_d ? 1 : 2;
      else if (wd)  m_owner = 2;
      else if (wi)  m_owner = 1;
      if (m_owner == 2) begin
        m_last_d = 1;
        e_pread = dmem_read; e_pwrite = dmem_write;
        e_addr = line_of(dmem_address);
        if (dmem_write) e_wdata = dmem_wdata;
      end else if (m_owner == 1) begin
        m_last_d = 0;
        e_pread = 1; e_pwrite = 0;
        e_addr = line_of(imem_address);
      end
    end
  end

  bit d_seen = 0;

  always @(negedge clk) begin
    chk("m_pread",  pmem_read,    e_pread);
    chk("m_pwrite", pmem_write,   e_pwrite);
    chk("m_addr",   pmem_address, e_addr);
    chk("m_wdata",  pmem_wdata,   e_wdata);
    chk("m_irdata", imem_rdata,   e_irdata);
    chk("m_drdata", dmem_rdata,   e_drdata);
    chk("m_iresp",  imem_resp,    e_iresp);
    chk("m_dresp",  dmem_resp,    e_dresp);
    if (dmem_resp) d_seen = 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant();
    int k = 0;
    while (!(pmem_read || pmem_write) && k < 20) begin
      tick();
      k++;
    end
    chk("grant_timeout", (k < 20), 1'b1);
  endtask

  task automatic l2(input int lat, input logic [LW-1:0] d);
    repeat (lat) tick();
    pmem_rdata = d;
    pmem_resp  = 1;
    tick();
    pmem_resp  = 0;
  endtask

  logic [LW-1:0] pat_a5, pat_d1, pat_i2, pat_wb, pat_d6;

  initial begin
    pat_a5 = {32{8'hA5}};
    pat_d1 = {8{32'hD1D1_0001}};
    pat_i2 = {8{32'h1212_3434}};
    pat_wb = {2{128'h11223344556677889900AABBCCDDEEFF}};
    pat_d6 = {8{32'h6666_0006}};

    repeat (2) tick();
    chk("rst_pread", pmem_read, 1'b0);
    chk("rst_addr", pmem_address, 32'h0);
    chk("rst_irdata", imem_rdata, '0);
    chk("rst_drdata", dmem_rdata, '0);
    rst = 1;
    tick();

    // Single I read
    d_seen = 0;
    imem_address = 32'h0000_1234;
    imem_read = 1;
    wait_grant();
    chk("t1_pread", pmem_read, 1'b1);
    chk("t1_addr", pmem_address, 32'h0000_1220);
    l2(2, pat_a5);
    chk("t1_iresp", imem_resp, 1'b1);
    chk("t1_irdata", imem_rdata, pat_a5);
    imem_read = 0;
    tick();
    chk("t1_iresp_off", imem_resp, 1'b0);
    chk("t1_no_dresp", d_seen, 1'b0);

    // Simultaneous requests: D first, then I, then D again
    imem_address = 32'h0000_2000;
    dmem_address = 32'h0000_D000;
    imem_read = 1;
    dmem_read = 1;
    wait_grant();
    chk("t2_first_d", pmem_address, 32'h0000_D000);
    l2(0, pat_d1);
    chk("t2_dresp", dmem_resp, 1'b1);
    dmem_read = 0;
    tick();
    wait_grant();
    chk("t2_second_i", pmem_address, 32'h0000_2000);
    l2(1, pat_i2);
    chk("t2_iresp", imem_resp, 1'b1);
    imem_read = 0;
    tick();
    imem_read = 1;
    dmem_read = 1;
    wait_grant();
    chk("t2_again_d", pmem_address, 32'h0000_D000);
    l2(0, pat_d1);
    dmem_read = 0;
    tick();
    wait_grant();
    chk("t2_again_i", pmem_address, 32'h0000_2000);
    l2(0, pat_i2);
    imem_read = 0;
    tick();

    // D writeback leaves dmem_rdata alone
    dmem_address = 32'h8000_0040;
    dmem_wdata = pat_wb;
    dmem_write = 1;
    wait_grant();
    chk("t3_pwrite", pmem_write, 1'b1);
    chk("t3_pread", pmem_read, 1'b0);
    chk("t3_addr", pmem_address, 32'h8000_0040);
    chk("t3_wdata", pmem_wdata, pat_wb);
    l2(2, pat_a5);
    chk("t3_dresp", dmem_resp, 1'b1);
    chk("t3_drdata", dmem_rdata, pat_d1);
    dmem_write = 0;
    tick();

    // I request raised while D is busy
    dmem_address = 32'h0000_3000;
    dmem_read = 1;
    wait_grant();
    imem_address = 32'h0000_4444;
    imem_read = 1;
    tick();
    tick();
    chk("t4_addr_held", pmem_address, 32'h0000_3000);
    l2(0, pat_d1);
    chk("t4_dresp", dmem_resp, 1'b1);
    dmem_read = 0;
    tick();
    chk("t4_idle", pmem_read, 1'b0);
    tick();
    chk("t4_i_grant", pmem_read, 1'b1);
    chk("t4_i_addr", pmem_address, 32'h0000_4440);
    l2(0, pat_i2);
    imem_read = 0;
    tick();

    // Reset mid-transaction
    imem_address = 32'h5555_0000;
    imem_read = 1;
    wait_grant();
    tick();
    #2 rst = 0;
    #1;
    chk("t5_pread", pmem_read, 1'b0);
    chk("t5_addr", pmem_address, 32'h0);
    chk("t5_wdata", pmem_wdata, '0);
    chk("t5_irdata", imem_rdata, '0);
    chk("t5_drdata", dmem_rdata, '0);
    imem_read = 0;
    tick();
    rst = 1;
    pmem_resp = 1;
    tick();
    pmem_resp = 0;
    chk("t5_no_iresp", imem_resp, 1'b0);
    chk("t5_no_dresp", dmem_resp, 1'b0);
    tick();
    chk("t5_no_iresp2", imem_resp, 1'b0);

    // Zero-wait L2: resp two edges after the request is raised
    dmem_address = 32'h6000_0020;
    dmem_read = 1;
    tick();
    chk("t6_grant", pmem_read, 1'b1);
    pmem_rdata = pat_d6;
    pmem_resp = 1;
    tick();
    pmem_resp = 0;
    chk("t6_dresp", dmem_resp, 1'b1);
    chk("t6_drdata", dmem_rdata, pat_d6);
    dmem_read = 0;
    tick();
    chk("t6_dresp_off", dmem_resp, 1'b0);
    tick();
    chk("t6_idle", pmem_read, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
